// File: rtl/mem_read_arbiter.sv
// ----------------------------------------------------------------------------
// mem_read_arbiter
//
// Purpose:
//   Shares the single data-read port of the memory between two cores.
//   One read is issued per cycle. Conflicts are resolved round-robin.
//   Each issued read is tagged with the requester id. The tag travels down a
//   MEM_LAT-deep pipeline, so the returning data is steered only to the core
//   that asked for it.
//
// Configuration macro:
//   MEMARB_FIXED_PRIO_EN - when defined, core 0 always wins a conflict and
//                          no priority state is built (legacy / bring-up).
//
// Parameters:
//   MEM_LAT    cycles from mem_ren/mem_raddr to valid mem_rdata (1..4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req0/1     core read request, held until granted
//   addr0/1    core word address [14:0], stable while req is high
//   gnt0/1     request accepted this cycle (combinational)
//   rvalid0/1  read data valid for that core this cycle
//   rdata0/1   read data for that core, 0 when rvalid is low
//   mem_ren    read issued to memory this cycle
//   mem_raddr  word address to memory, 0 when mem_ren is low
//   mem_rdata  memory read data, valid MEM_LAT cycles after issue
// ----------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [14:0] addr0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic [14:0] addr1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [15:0] rdata1,
    output logic        mem_ren,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata
);

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_pick1;   // winner of a conflict: 1 = core 1
    logic               w_ret_v;
    logic               w_ret_id;
    logic [MEM_LAT-1:0] r_tag_v;
    logic [MEM_LAT-1:0] r_tag_id;

`ifdef MEMARB_FIXED_PRIO_EN
    assign w_pick1 = 1'b0;
`else
    logic r_prio;

    // Favour whichever core lost the last grant; hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt0 || w_gnt1) begin
            r_prio <= w_gnt0;
        end
    end

    assign w_pick1 = r_prio;
`endif

    // Requests are ignored entirely while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                w_gnt0 = ~w_pick1;
                w_gnt1 = w_pick1;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign mem_ren   = w_gnt0 | w_gnt1;
    assign mem_raddr = w_gnt1 ? addr1 : (w_gnt0 ? addr0 : 15'd0);

    // Tag pipeline: stage 0 captures this cycle's issue, every stage shifts
    // unconditionally, so the last stage lines up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_gnt0 | w_gnt1;
            r_tag_id[0] <= w_gnt1;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_ret_v  = r_tag_v[MEM_LAT-1];
    assign w_ret_id = r_tag_id[MEM_LAT-1];

    assign rvalid0 = w_ret_v & ~w_ret_id;
    assign rvalid1 = w_ret_v &  w_ret_id;
    assign rdata0  = rvalid0 ? mem_rdata : 16'd0;
    assign rdata1  = rvalid1 ? mem_rdata : 16'd0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_read_arbiter
//
// Directed stimulus for mem_read_arbiter. A behavioural memory returns a
// known function of the issued address after LAT cycles. Each expected
// return is queued when its grant is checked, and a separate monitor pops
// the queue whenever the DUT presents rvalid.
// ----------------------------------------------------------------------------
module tb_mem_read_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          id;
        logic [15:0] data;
        int          due;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0;
    logic [14:0] addr0 = 15'd0;
    logic        gnt0;
    logic        rvalid0;
    logic [15:0] rdata0;
    logic        req1 = 1'b0;
    logic [14:0] addr1 = 15'd0;
    logic        gnt1;
    logic        rvalid1;
    logic [15:0] rdata1;
    logic        mem_ren;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   prio_m = 1'b0;
    ret_t sb[$];

    logic [14:0] m_addr [LAT];

    mem_read_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mfun(input logic [14:0] a);
        return {a, 1'b1} ^ 16'h5A3C;
    endfunction

    // Behavioural memory: data for an address issued in cycle k is
    // presented in cycle k+LAT.
    always @(posedge clk) begin
        m_addr[0] <= mem_raddr;
        for (int i = 1; i < LAT; i++) m_addr[i] <= m_addr[i-1];
    end
    assign mem_rdata = mfun(m_addr[LAT-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: consumes expected returns whenever the DUT presents one.
    always @(negedge clk) begin
        ret_t e;
        if (rvalid0 && rvalid1) chk("rvalid_both", 32'd1, 32'd0);
        if (rvalid0 || rvalid1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ret_id", {31'd0, rvalid1}, {31'd0, e.id});
                chk("ret_data", {16'd0, (e.id ? rdata1 : rdata0)}, {16'd0, e.data});
                chk("ret_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("missing_rvalid", 32'd0, 32'd1);
        end
        if (!rvalid0) chk("rdata0_idle", {16'd0, rdata0}, 32'd0);
        if (!rvalid1) chk("rdata1_idle", {16'd0, rdata1}, 32'd0);
    end

    // One bench cycle: drive after the rising edge, check the combinational
    // grant on the falling edge and queue the expected return.
    task automatic step(input bit r, input bit q0, input logic [14:0] a0,
                        input bit q1, input logic [14:0] a1);
        bit          eg0, eg1;
        logic [14:0] ea;
        ret_t        e;
        @(posedge clk);
        #1;
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
        if (r) begin
            sb.delete();
            prio_m = 1'b0;
        end
        @(negedge clk);
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!r) begin
            if (q0 && q1) begin
`ifdef MEMARB_FIXED_PRIO_EN
                eg0 = 1'b1;
`else
                eg0 = ~prio_m;
                eg1 = prio_m;
`endif
            end else begin
                eg0 = q0;
                eg1 = q1;
            end
        end
        ea = eg1 ? a1 : (eg0 ? a0 : 15'd0);
        chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        chk("mem_ren", {31'd0, mem_ren}, {31'd0, (eg0 | eg1)});
        chk("mem_raddr", {17'd0, mem_raddr}, {17'd0, ea});
        if (eg0 || eg1) begin
            e.id   = eg1;
            e.data = mfun(ea);
            e.due  = cyc + LAT;
            sb.push_back(e);
            prio_m = eg0;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        // Reset held with both cores requesting: everything stays quiet.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 15'h0010, 1'b1, 15'h0020);
        step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);

        // Single request from each core, including the top address.
        step(1'b0, 1'b1, 15'h0010, 1'b0, 15'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);
        step(1'b0, 1'b0, 15'h0000, 1'b1, 15'h7FFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);

        // Continuous conflict: grants alternate.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 15'h0100, 1'b1, 15'h0200);
        step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);

        // Back-to-back core 1 reads, fully pipelined.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 15'h0000, 1'b1, 15'(i));

        // Mixed traffic with idle gaps and alternating lone requesters.
        step(1'b0, 1'b1, 15'h1234, 1'b0, 15'h0000);
        step(1'b0, 1'b1, 15'h0ABC, 1'b1, 15'h0DEF);
        step(1'b0, 1'b1, 15'h0ABC, 1'b0, 15'h0000);
        step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);
        step(1'b0, 1'b0, 15'h0000, 1'b1, 15'h4321);
        step(1'b0, 1'b1, 15'h0001, 1'b1, 15'h0002);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);

        // Reset one cycle after a grant: its return must never appear.
        step(1'b0, 1'b0, 15'h0000, 1'b1, 15'h0055);
        step(1'b0, 1'b1, 15'h0077, 1'b0, 15'h0000);
        step(1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000);
        step(1'b1, 1'b1, 15'h0033, 1'b1, 15'h0044);
        // First conflict after reset goes to core 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 15'h0033, 1'b1, 15'h0044);

        for (int i = 0; i < LAT + 3; i++) step(1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
